procb_wr: RTL and testbench
===========================

// Module: procb_wr
// PURPOSE
// - Writer end of the per-thread procb record buffer. Takes procb records from
//   the host/CPU input stream and writes them into the buffer's write port.
// - Each thread gets a batch of records. A batch ends on a finish/stop record,
//   or when the thread's slots are full.
// - A batch is written only when the thread's buffered count (wr_cnt) is 0,
//   i.e. the engine has consumed the previous batch and reset the count.
// PARAMETERS
// - N_THREADS       16  threads served by the buffer
// - N_THREADS_MSB   `MSB(N_THREADS-1)  thread index MSB
// - D_WIDTH         `PROCB_D_WIDTH  record width; bit D_WIDTH-1=FIN, bit D_WIDTH-2=STOP
// - A_WIDTH         `PROCB_A_WIDTH  count width; N_REC = 2**(A_WIDTH-1) slots/thread
// PORTS
// - CLK            in   1              clock
// - RST_N          in   1              asynchronous reset, active low
// - in_valid       in   1              upstream record valid
// - in_ready       out  1              upstream accept; transfer = in_valid & in_ready
// - in_thread      in   N_THREADS_MSB+1  thread of the record
// - in_data        in   D_WIDTH        procb record
// - wr_thread_num  out  N_THREADS_MSB+1  to buffer write port
// - wr_en          out  1              to buffer: write one record
// - dout           out  D_WIDTH        to buffer din
// - wr_cnt         in   A_WIDTH        from buffer: registered count of the addressed thread
// - buf_err        in   1              from buffer err
// - busy           out  1              state != IDLE
// - batch_done     out  1              1-cycle pulse when a batch ends
// - err            out  1              sticky error
// BEHAVIOUR
// - Reset (async, RST_N=0): state=IDLE; the following are all 0:
//   in_ready, wr_en, wr_thread_num, dout, busy, batch_done, err, rec_cnt.
//   Takes effect mid-batch with no completion pulse. A partially written batch
//   stays in the buffer.
// - wr_cnt reflects wr_thread_num with 1-cycle latency. The buffer increments it
//   in the same cycle as wr_en.
// - IDLE: in_ready=0. On in_valid, latch cur_thread=in_thread, drive
//   wr_thread_num=cur_thread, go to SEL.
// - SEL: one cycle while wr_cnt settles, then WAIT.
// - WAIT: wr_en=0, which lets an enqueued reader reset land. If wr_cnt==0, go to
//   WRITE and clear rec_cnt; otherwise stay (poll every cycle, no timeout).
// - WRITE: in_ready=1. On each transfer: wr_en=1, dout=in_data, rec_cnt+=1.
//   - wr_en is combinational from the transfer; 0 latency, 1 record/cycle.
//   - If in_data FIN|STOP: go to DONE.
//   - Else if rec_cnt+1==N_REC: buffer is full, go back to WAIT with the same
//     thread. The batch resumes once the reader resets wr_cnt.
//   - in_valid low: stay, wr_en=0.
// - DONE: batch_done=1 for one cycle, then IDLE.
//   - Records for the next thread are accepted no earlier than 2 cycles after
//     the last write (DONE, then IDLE).
// - Thread lock: in WRITE, a transfer with in_thread!=cur_thread sets err.
//   - The record is written anyway to cur_thread.
// - err sticky until reset. Set by buf_err=1 or by a thread-lock violation.
//   Operation continues after err.
// - rec_cnt: A_WIDTH bits and never wraps, because full is detected at
//   N_REC-1 before the increment. A FIN/STOP on the N_REC-th record goes to
//   DONE, not to WAIT.
// - Simultaneous full and FIN on the same record: DONE wins.
// TESTING
// 1. Reset released, thread 3 has wr_cnt=0, three records sent with the last
//    one FIN -> wr_en high 3 consecutive cycles, addr 3, dout matches input,
//    batch_done 1 cycle later.
// 2. Thread 5 with wr_cnt=2 (unconsumed) -> in_ready stays 0. Force wr_cnt=0
//    -> writes start the cycle after it is seen.
// 3. N_REC=4: six records with no FIN until #6 -> 4 writes, then WAIT. After
//    the reader reset: 2 writes, batch_done. No err.
// 4. in_thread changes from 2 to 7 mid-batch -> err=1 sticky; the record still
//    goes to thread 2.
// 5. RST_N low during WRITE after 2 records -> wr_en=0 and in_ready=0 at once,
//    state IDLE, no batch_done. The next batch restarts from SEL.
// 6. buf_err pulsed for 1 cycle -> err=1 held until reset. in_valid gaps in
//    WRITE -> wr_en low during the gaps.

Source files
------------

// File: rtl/procb_wr.sv
// procb_wr: writer end of the per-thread procb record buffer.
// Gathers one batch of records per thread and streams them into the buffer write port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no batch; waiting for a record to pick the next thread
// S_SEL   | thread address presented, buffer count settling
// S_WAIT  | waiting for the reader to drain the thread (wr_cnt == 0)
// S_WRITE | accepting records, one write per transfer
// S_DONE  | batch ended; batch_done pulse
module procb_wr #(
  parameter int N_THREADS     = 16,
  parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1,
  parameter int D_WIDTH       = 32,
  parameter int A_WIDTH       = 3
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_THREADS_MSB:0] in_thread,
  input  logic [D_WIDTH-1:0]     in_data,
  output logic [N_THREADS_MSB:0] wr_thread_num,
  output logic                   wr_en,
  output logic [D_WIDTH-1:0]     dout,
  input  logic [A_WIDTH-1:0]     wr_cnt,
  input  logic                   buf_err,
  output logic                   busy,
  output logic                   batch_done,
  output logic                   err
);

  localparam logic [A_WIDTH-1:0] N_REC = A_WIDTH'(2 ** (A_WIDTH - 1));

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t             state;
  logic [A_WIDTH-1:0] rec_cnt;
  logic               xfer;
  logic               last_rec;
  logic               thread_err;

  // Writes follow the handshake directly so records stream at one per cycle.
  assign xfer       = in_valid & in_ready;
  assign wr_en      = xfer;
  assign dout       = xfer ? in_data : '0;
  assign last_rec   = in_data[D_WIDTH-1] | in_data[D_WIDTH-2];
  assign thread_err = xfer && (in_thread != wr_thread_num);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= S_IDLE;
      in_ready      <= 1'b0;
      wr_thread_num <= '0;
      busy          <= 1'b0;
      batch_done    <= 1'b0;
      err           <= 1'b0;
      rec_cnt       <= '0;
    end else begin
      batch_done <= 1'b0;
      if (buf_err || thread_err)
        err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            wr_thread_num <= in_thread;
            busy          <= 1'b1;
            state         <= S_SEL;
          end
        end
        S_SEL: state <= S_WAIT;
        S_WAIT: begin
          if (wr_cnt == '0) begin
            rec_cnt  <= '0;
            in_ready <= 1'b1;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (xfer) begin
            rec_cnt <= rec_cnt + 1'b1;
            // A terminating record ends the batch even when it also fills the slots.
            if (last_rec) begin
              in_ready   <= 1'b0;
              batch_done <= 1'b1;
              state      <= S_DONE;
            end else if (rec_cnt + 1'b1 == N_REC) begin
              in_ready <= 1'b0;
              state    <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_procb_wr.sv
// tb_procb_wr: directed bench for procb_wr with a small per-thread buffer count model.
module tb_procb_wr;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int TW = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] in_thread = '0;
  logic [DW-1:0] in_data = '0;
  logic [TW-1:0] wr_thread_num;
  logic          wr_en;
  logic [DW-1:0] dout;
  logic [AW-1:0] wr_cnt = '0;
  logic          buf_err = 1'b0;
  logic          busy;
  logic          batch_done;
  logic          err;

  int compared = 0;
  int mismatched = 0;

  // buffer model: per-thread count, reader resets via clr_req
  logic [AW-1:0] cnt [16] = '{default: '0};
  logic          clr_req = 1'b0;
  logic [TW-1:0] clr_thr = '0;
  logic [AW-1:0] clr_val = '0;

  procb_wr #(.N_THREADS(16), .D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
    .in_thread(in_thread), .in_data(in_data), .wr_thread_num(wr_thread_num),
    .wr_en(wr_en), .dout(dout), .wr_cnt(wr_cnt), .buf_err(buf_err),
    .busy(busy), .batch_done(batch_done), .err(err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (clr_req) cnt[clr_thr] <= clr_val;
    else if (wr_en) cnt[wr_thread_num] <= cnt[wr_thread_num] + 1'b1;
    if (clr_req && clr_thr == wr_thread_num) wr_cnt <= clr_val;
    else if (wr_en) wr_cnt <= cnt[wr_thread_num] + 1'b1;
    else wr_cnt <= cnt[wr_thread_num];
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge CLK);
    #3;
    compared++; if ({in_ready, wr_en, busy, batch_done, err} !== 5'b0) begin mismatched++; $display("FAIL rst_flags got %b want 00000", {in_ready, wr_en, busy, batch_done, err}); end
    compared++; if (wr_thread_num !== '0 || dout !== '0) begin mismatched++; $display("FAIL rst_bus got thr=%h dout=%h want 0/0", wr_thread_num, dout); end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    tick;
    #2;
    compared++; if (busy !== 1'b0 || in_ready !== 1'b0) begin mismatched++; $display("FAIL rst_release got busy=%b rdy=%b want 0/0", busy, in_ready); end
    tick;
  endtask

  task automatic test_basic;
    logic [DW-1:0] d [3];
    d[0] = 32'h0000_0131; d[1] = 32'h0000_0232; d[2] = 32'h8000_0333;
    in_valid = 1'b1; in_thread = 4'd3; in_data = d[0];
    for (int i = 0; i < 3; i++) begin
      #2;
      compared++; if (in_ready !== 1'b0 || wr_en !== 1'b0) begin mismatched++; $display("FAIL basic_pre[%0d] got rdy=%b wr=%b want 0/0", i, in_ready, wr_en); end
      tick;
    end
    for (int i = 0; i < 3; i++) begin
      in_data = d[i];
      #2;
      compared++; if (wr_en !== 1'b1) begin mismatched++; $display("FAIL basic_wr[%0d] got %b want 1", i, wr_en); end
      compared++; if (dout !== d[i]) begin mismatched++; $display("FAIL basic_dout[%0d] got %h want %h", i, dout, d[i]); end
      compared++; if (wr_thread_num !== 4'd3) begin mismatched++; $display("FAIL basic_thr[%0d] got %0d want 3", i, wr_thread_num); end
      compared++; if (batch_done !== 1'b0) begin mismatched++; $display("FAIL basic_early_done[%0d] got %b want 0", i, batch_done); end
      tick;
    end
    in_valid = 1'b0; in_data = '0;
    #2;
    compared++; if (batch_done !== 1'b1 || wr_en !== 1'b0) begin mismatched++; $display("FAIL basic_done got done=%b wr=%b want 1/0", batch_done, wr_en); end
    tick;
    #2;
    compared++; if (batch_done !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL basic_idle got done=%b busy=%b want 0/0", batch_done, busy); end
    tick;
  endtask

  task automatic test_wait_cnt;
    clr_req = 1'b1; clr_thr = 4'd5; clr_val = 3'd2;
    tick;
    clr_req = 1'b0;
    in_valid = 1'b1; in_thread = 4'd5; in_data = 32'h4000_0555;
    for (int i = 0; i < 5; i++) begin
      #2;
      compared++; if (in_ready !== 1'b0 || wr_en !== 1'b0) begin mismatched++; $display("FAIL wait_hold[%0d] got rdy=%b wr=%b want 0/0", i, in_ready, wr_en); end
      tick;
    end
    clr_req = 1'b1; clr_thr = 4'd5; clr_val = 3'd0;
    tick;
    clr_req = 1'b0;
    #2;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL wait_seen got rdy=%b want 0", in_ready); end
    tick;
    #2;
    compared++; if (wr_en !== 1'b1 || dout !== 32'h4000_0555) begin mismatched++; $display("FAIL wait_start got wr=%b dout=%h want 1/40000555", wr_en, dout); end
    tick;
    in_valid = 1'b0;
    #2;
    compared++; if (batch_done !== 1'b1) begin mismatched++; $display("FAIL wait_done got %b want 1", batch_done); end
    tick; tick;
  endtask

  task automatic test_full;
    logic [DW-1:0] r [6];
    for (int k = 0; k < 6; k++) r[k] = 32'h0000_1100 + k;
    r[5][DW-1] = 1'b1;
    in_valid = 1'b1; in_thread = 4'd1; in_data = r[0];
    tick; tick; tick;
    for (int k = 0; k < 4; k++) begin
      in_data = r[k];
      #2;
      compared++; if (wr_en !== 1'b1 || dout !== r[k]) begin mismatched++; $display("FAIL full_wr[%0d] got wr=%b dout=%h want 1/%h", k, wr_en, dout, r[k]); end
      tick;
    end
    in_data = r[4];
    for (int i = 0; i < 3; i++) begin
      #2;
      compared++; if (wr_en !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL full_wait[%0d] got wr=%b rdy=%b busy=%b want 0/0/1", i, wr_en, in_ready, busy); end
      tick;
    end
    clr_req = 1'b1; clr_thr = 4'd1; clr_val = 3'd0;
    tick;
    clr_req = 1'b0;
    tick;
    for (int k = 4; k < 6; k++) begin
      in_data = r[k];
      #2;
      compared++; if (wr_en !== 1'b1 || dout !== r[k]) begin mismatched++; $display("FAIL full_resume[%0d] got wr=%b dout=%h want 1/%h", k, wr_en, dout, r[k]); end
      tick;
    end
    in_valid = 1'b0;
    #2;
    compared++; if (batch_done !== 1'b1 || err !== 1'b0) begin mismatched++; $display("FAIL full_done got done=%b err=%b want 1/0", batch_done, err); end
    tick; tick;
    compared++; if (cnt[1] !== 3'd2) begin mismatched++; $display("FAIL full_cnt got %0d want 2", cnt[1]); end
  endtask

  task automatic test_full_fin;
    in_valid = 1'b1; in_thread = 4'd8; in_data = 32'h0000_8800;
    tick; tick; tick;
    for (int k = 0; k < 4; k++) begin
      in_data = (k == 3) ? 32'h8000_8803 : 32'h0000_8800 + k;
      #2;
      compared++; if (wr_en !== 1'b1) begin mismatched++; $display("FAIL fullfin_wr[%0d] got %b want 1", k, wr_en); end
      tick;
    end
    in_valid = 1'b0;
    #2;
    compared++; if (batch_done !== 1'b1 || in_ready !== 1'b0) begin mismatched++; $display("FAIL fullfin_done got done=%b rdy=%b want 1/0", batch_done, in_ready); end
    tick;
    #2;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL fullfin_idle got busy=%b want 0", busy); end
    tick;
  endtask

  task automatic test_thread_lock;
    in_valid = 1'b1; in_thread = 4'd2; in_data = 32'h0000_2001;
    tick; tick; tick;
    #2;
    compared++; if (wr_en !== 1'b1 || err !== 1'b0) begin mismatched++; $display("FAIL lock_first got wr=%b err=%b want 1/0", wr_en, err); end
    tick;
    in_thread = 4'd7; in_data = 32'h0000_2002;
    #2;
    compared++; if (wr_en !== 1'b1 || wr_thread_num !== 4'd2) begin mismatched++; $display("FAIL lock_wr got wr=%b thr=%0d want 1/2", wr_en, wr_thread_num); end
    tick;
    in_data = 32'h8000_2003;
    #2;
    compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL lock_err got %b want 1", err); end
    tick;
    in_valid = 1'b0;
    #2;
    compared++; if (batch_done !== 1'b1) begin mismatched++; $display("FAIL lock_done got %b want 1", batch_done); end
    tick; tick;
    #2;
    compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL lock_sticky got %b want 1", err); end
    compared++; if (cnt[2] !== 3'd3 || cnt[7] !== 3'd0) begin mismatched++; $display("FAIL lock_dest got t2=%0d t7=%0d want 3/0", cnt[2], cnt[7]); end
    tick;
  endtask

  task automatic test_reset_midbatch;
    in_valid = 1'b1; in_thread = 4'd4; in_data = 32'h0000_4001;
    tick; tick; tick;
    tick;
    in_data = 32'h0000_4002;
    tick;
    in_data = 32'h0000_4003;
    RST_N = 1'b0;
    #2;
    compared++; if (wr_en !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL mrst_flags got wr=%b rdy=%b busy=%b want 0/0/0", wr_en, in_ready, busy); end
    compared++; if (batch_done !== 1'b0 || err !== 1'b0 || wr_thread_num !== '0) begin mismatched++; $display("FAIL mrst_state got done=%b err=%b thr=%0d want 0/0/0", batch_done, err, wr_thread_num); end
    in_valid = 1'b0;
    tick;
    RST_N = 1'b1;
    #2;
    compared++; if (batch_done !== 1'b0 || cnt[4] !== 3'd2) begin mismatched++; $display("FAIL mrst_partial got done=%b cnt=%0d want 0/2", batch_done, cnt[4]); end
    tick;
    clr_req = 1'b1; clr_thr = 4'd4; clr_val = 3'd0;
    tick;
    clr_req = 1'b0;
    in_valid = 1'b1; in_data = 32'h8000_4004;
    for (int i = 0; i < 3; i++) begin
      #2;
      compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL mrst_restart[%0d] got rdy=%b want 0", i, in_ready); end
      tick;
    end
    #2;
    compared++; if (wr_en !== 1'b1 || dout !== 32'h8000_4004) begin mismatched++; $display("FAIL mrst_write got wr=%b dout=%h want 1/80004004", wr_en, dout); end
    tick;
    in_valid = 1'b0;
    #2;
    compared++; if (batch_done !== 1'b1) begin mismatched++; $display("FAIL mrst_done got %b want 1", batch_done); end
    tick; tick;
  endtask

  task automatic test_buf_err_gaps;
    #2;
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL berr_pre got %b want 0", err); end
    tick;
    buf_err = 1'b1;
    tick;
    buf_err = 1'b0;
    #2;
    compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL berr_set got %b want 1", err); end
    tick; tick;
    in_valid = 1'b1; in_thread = 4'd6; in_data = 32'h0000_6001;
    tick; tick; tick;
    #2;
    compared++; if (wr_en !== 1'b1 || dout !== 32'h0000_6001) begin mismatched++; $display("FAIL gap_w1 got wr=%b dout=%h want 1/00006001", wr_en, dout); end
    tick;
    in_valid = 1'b0;
    #2;
    compared++; if (wr_en !== 1'b0 || in_ready !== 1'b1) begin mismatched++; $display("FAIL gap_1 got wr=%b rdy=%b want 0/1", wr_en, in_ready); end
    tick;
    in_valid = 1'b1; in_data = 32'h0000_6002;
    #2;
    compared++; if (wr_en !== 1'b1 || dout !== 32'h0000_6002) begin mismatched++; $display("FAIL gap_w2 got wr=%b dout=%h want 1/00006002", wr_en, dout); end
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      compared++; if (wr_en !== 1'b0 || dout !== '0) begin mismatched++; $display("FAIL gap_2[%0d] got wr=%b dout=%h want 0/0", i, wr_en, dout); end
      tick;
    end
    in_valid = 1'b1; in_data = 32'h8000_6003;
    #2;
    compared++; if (wr_en !== 1'b1) begin mismatched++; $display("FAIL gap_w3 got %b want 1", wr_en); end
    tick;
    in_valid = 1'b0;
    #2;
    compared++; if (batch_done !== 1'b1 || err !== 1'b1) begin mismatched++; $display("FAIL gap_done got done=%b err=%b want 1/1", batch_done, err); end
    tick; tick;
    compared++; if (cnt[6] !== 3'd3) begin mismatched++; $display("FAIL gap_cnt got %0d want 3", cnt[6]); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wait_cnt;
    test_full;
    test_full_fin;
    test_thread_lock;
    test_reset_midbatch;
    test_buf_err_gaps;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
